// File: rtl/sys_array_feeder.sv
// Operand sequencer for the 2x2 FP systolic multiplier: skews A/B into the
// array, waits for completion (with timeout) and holds the result matrix.
module sys_array_feeder #(
  parameter int unsigned BEAT_GAP = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a00,
  input  logic [31:0] a01,
  input  logic [31:0] a10,
  input  logic [31:0] a11,
  input  logic [31:0] b00,
  input  logic [31:0] b01,
  input  logic [31:0] b10,
  input  logic [31:0] b11,
  output logic        load_in,
  output logic [31:0] row_in_row0,
  output logic [31:0] row_in_row1,
  output logic [31:0] col_in_col0,
  output logic [31:0] col_in_col1,
  input  logic        arr_done,
  input  logic [31:0] arr_c00,
  input  logic [31:0] arr_c01,
  input  logic [31:0] arr_c10,
  input  logic [31:0] arr_c11,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c00,
  output logic [31:0] c01,
  output logic [31:0] c10,
  output logic [31:0] c11,
  output logic        err_timeout,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    GAP,
    WAIT,
    HOLD
  } state_e;

  localparam bit HAS_GAP = (BEAT_GAP != 0);
  localparam logic [3:0] GAP_LAST =
    4'((BEAT_GAP == 0) ? 0 : BEAT_GAP - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [1:0]  k_q;
  logic [3:0]  gap_q;
  logic [7:0]  wcnt_q;

  logic [31:0] a00_q, a01_q, a10_q, a11_q;
  logic [31:0] b00_q, b01_q, b10_q, b11_q;

  logic        in_ready_q;
  logic        load_q;
  logic [31:0] row0_q, row1_q;
  logic [31:0] col0_q, col1_q;
  logic        out_valid_q;
  logic [31:0] c00_q, c01_q, c10_q, c11_q;
  logic        err_q;
  logic        busy_q;

  logic [1:0]  nk_d;
  logic [31:0] sa00, sb00;
  logic [31:0] row0_d, row1_d;
  logic [31:0] col0_d, col1_d;

  // Data for the next beat; beat 0 is launched straight from the
  // handshake, before the operand registers are loaded.
  always_comb begin
    nk_d   = (state_q == IDLE) ? 2'd0 : k_q + 2'd1;
    sa00   = (state_q == IDLE) ? a00 : a00_q;
    sb00   = (state_q == IDLE) ? b00 : b00_q;
    row0_d = '0;
    row1_d = '0;
    col0_d = '0;
    col1_d = '0;
    unique case (1'b1)
      nk_d == 2'd0: begin
        row0_d = sa00;
        col0_d = sb00;
      end
      nk_d == 2'd1: begin
        row0_d = a01_q;
        row1_d = a10_q;
        col0_d = b10_q;
        col1_d = b01_q;
      end
      nk_d == 2'd2: begin
        row1_d = a11_q;
        col1_d = b11_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      gap_q       <= '0;
      wcnt_q      <= '0;
      a00_q       <= '0;
      a01_q       <= '0;
      a10_q       <= '0;
      a11_q       <= '0;
      b00_q       <= '0;
      b01_q       <= '0;
      b10_q       <= '0;
      b11_q       <= '0;
      in_ready_q  <= 1'b1;
      load_q      <= 1'b0;
      row0_q      <= '0;
      row1_q      <= '0;
      col0_q      <= '0;
      col1_q      <= '0;
      out_valid_q <= 1'b0;
      c00_q       <= '0;
      c01_q       <= '0;
      c10_q       <= '0;
      c11_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a00_q      <= a00;
            a01_q      <= a01;
            a10_q      <= a10;
            a11_q      <= a11;
            b00_q      <= b00;
            b01_q      <= b01;
            b10_q      <= b10;
            b11_q      <= b11;
            state_q    <= FEED;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            load_q     <= 1'b1;
            row0_q     <= row0_d;
            row1_q     <= row1_d;
            col0_q     <= col0_d;
            col1_q     <= col1_d;
          end
        end
        FEED: begin
          if (k_q == 2'd2 || HAS_GAP) begin
            load_q <= 1'b0;
            row0_q <= '0;
            row1_q <= '0;
            col0_q <= '0;
            col1_q <= '0;
            if (k_q == 2'd2) begin
              state_q <= WAIT;
              wcnt_q  <= '0;
            end else begin
              state_q <= GAP;
              gap_q   <= '0;
            end
          end else begin
            k_q    <= k_q + 2'd1;
            load_q <= 1'b1;
            row0_q <= row0_d;
            row1_q <= row1_d;
            col0_q <= col0_d;
            col1_q <= col1_d;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= FEED;
            k_q     <= k_q + 2'd1;
            load_q  <= 1'b1;
            row0_q  <= row0_d;
            row1_q  <= row1_d;
            col0_q  <= col0_d;
            col1_q  <= col1_d;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        WAIT: begin
          // A completion in the final wait cycle still wins over timeout.
          if (arr_done) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            err_q       <= 1'b0;
            c00_q       <= arr_c00;
            c01_q       <= arr_c01;
            c10_q       <= arr_c10;
            c11_q       <= arr_c11;
          end else if (wcnt_q == WAIT_LAST) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            err_q       <= 1'b1;
            c00_q       <= '0;
            c01_q       <= '0;
            c10_q       <= '0;
            c11_q       <= '0;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign load_in     = load_q;
  assign row_in_row0 = row0_q;
  assign row_in_row1 = row1_q;
  assign col_in_col0 = col0_q;
  assign col_in_col1 = col1_q;
  assign out_valid   = out_valid_q;
  assign c00         = c00_q;
  assign c01         = c01_q;
  assign c10         = c10_q;
  assign c11         = c11_q;
  assign err_timeout = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sys_array_feeder.sv
// Directed bench for sys_array_feeder: one instance with no beat gap and a
// short timeout, one with the default gap/timeout.
module tb_sys_array_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv0, iv4;
  logic [31:0] a00, a01, a10, a11;
  logic [31:0] b00, b01, b10, b11;
  logic        arr_done;
  logic [31:0] ac00, ac01, ac10, ac11;
  logic        out_ready;

  logic        g0_rdy, g0_ld, g0_ov, g0_err, g0_busy;
  logic [31:0] g0_r0, g0_r1, g0_k0, g0_k1;
  logic [31:0] g0_c00, g0_c01, g0_c10, g0_c11;
  logic        g4_rdy, g4_ld, g4_ov, g4_err, g4_busy;
  logic [31:0] g4_r0, g4_r1, g4_k0, g4_k1;
  logic [31:0] g4_c00, g4_c01, g4_c10, g4_c11;

  sys_array_feeder #(.BEAT_GAP(0), .TIMEOUT(8)) u_g0 (
    .clk(clk), .rst(rst),
    .in_valid(iv0), .in_ready(g0_rdy),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .load_in(g0_ld),
    .row_in_row0(g0_r0), .row_in_row1(g0_r1),
    .col_in_col0(g0_k0), .col_in_col1(g0_k1),
    .arr_done(arr_done),
    .arr_c00(ac00), .arr_c01(ac01),
    .arr_c10(ac10), .arr_c11(ac11),
    .out_valid(g0_ov), .out_ready(out_ready),
    .c00(g0_c00), .c01(g0_c01), .c10(g0_c10), .c11(g0_c11),
    .err_timeout(g0_err), .busy(g0_busy)
  );

  sys_array_feeder #(.BEAT_GAP(4), .TIMEOUT(64)) u_g4 (
    .clk(clk), .rst(rst),
    .in_valid(iv4), .in_ready(g4_rdy),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .load_in(g4_ld),
    .row_in_row0(g4_r0), .row_in_row1(g4_r1),
    .col_in_col0(g4_k0), .col_in_col1(g4_k1),
    .arr_done(arr_done),
    .arr_c00(ac00), .arr_c01(ac01),
    .arr_c10(ac10), .arr_c11(ac11),
    .out_valid(g4_ov), .out_ready(out_ready),
    .c00(g4_c00), .c01(g4_c01), .c10(g4_c10), .c11(g4_c11),
    .err_timeout(g4_err), .busy(g4_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [31:0] p0, p1, p2, p3,
                         input logic [31:0] q0, q1, q2, q3);
    a00 = p0; a01 = p1; a10 = p2; a11 = p3;
    b00 = q0; b01 = q1; b10 = q2; b11 = q3;
  endtask

  task automatic set_res(input logic [31:0] r0, r1, r2, r3);
    ac00 = r0; ac01 = r1; ac10 = r2; ac11 = r3;
  endtask

  initial begin
    rst = 1'b1;
    iv0 = 1'b0;
    iv4 = 1'b0;
    arr_done = 1'b0;
    out_ready = 1'b0;
    set_ops('0, '0, '0, '0, '0, '0, '0, '0);
    set_res('0, '0, '0, '0);
    tick();
    tick();
    rst = 1'b0;

    chk("rst_rdy", 32'(g0_rdy), 32'd1);
    chk("rst_ld", 32'(g0_ld), 32'd0);
    chk("rst_busy", 32'(g0_busy), 32'd0);
    chk("rst_ov", 32'(g0_ov), 32'd0);
    chk("rst_err", 32'(g0_err), 32'd0);
    chk("rst_data", g0_r0 | g0_r1 | g0_k0 | g0_k1, 32'd0);
    chk("rst_c", g0_c00 | g0_c01 | g0_c10 | g0_c11, 32'd0);
    chk("rst_rdy4", 32'(g4_rdy), 32'd1);

    // G=0 feed skew; in_valid stays high, operands change after accept
    set_ops(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h3F800000, 32'h0, 32'h0, 32'h3F800000);
    iv0 = 1'b1;
    tick();
    set_ops(32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004,
            32'hD0000001, 32'hD0000002, 32'hD0000003, 32'hD0000004);
    chk("b0_ld", 32'(g0_ld), 32'd1);
    chk("b0_row0", g0_r0, 32'h3F800000);
    chk("b0_row1", g0_r1, 32'h0);
    chk("b0_col0", g0_k0, 32'h3F800000);
    chk("b0_col1", g0_k1, 32'h0);
    chk("b0_busy", 32'(g0_busy), 32'd1);
    chk("b0_rdy", 32'(g0_rdy), 32'd0);
    tick();
    chk("b1_ld", 32'(g0_ld), 32'd1);
    chk("b1_row0", g0_r0, 32'h40000000);
    chk("b1_row1", g0_r1, 32'h40400000);
    chk("b1_col0", g0_k0, 32'h0);
    chk("b1_col1", g0_k1, 32'h0);
    tick();
    chk("b2_ld", 32'(g0_ld), 32'd1);
    chk("b2_row0", g0_r0, 32'h0);
    chk("b2_row1", g0_r1, 32'h40800000);
    chk("b2_col0", g0_k0, 32'h0);
    chk("b2_col1", g0_k1, 32'h3F800000);
    tick();
    chk("w_ld", 32'(g0_ld), 32'd0);
    chk("w_data", g0_r0 | g0_r1 | g0_k0 | g0_k1, 32'd0);
    chk("w_rdy", 32'(g0_rdy), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("w_ov0", 32'(g0_ov), 32'd0);
    end
    // done on wait count 7 == TIMEOUT-1 beats the timeout
    set_res(32'h40E00000, 32'h41200000, 32'h41700000, 32'h41B00000);
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    chk("late_ov", 32'(g0_ov), 32'd1);
    chk("late_err", 32'(g0_err), 32'd0);
    chk("late_c00", g0_c00, 32'h40E00000);
    chk("late_c11", g0_c11, 32'h41B00000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rel_ov", 32'(g0_ov), 32'd0);
    chk("rel_rdy", 32'(g0_rdy), 32'd1);
    chk("rel_busy", 32'(g0_busy), 32'd0);
    tick();
    iv0 = 1'b0;
    chk("y_ld", 32'(g0_ld), 32'd1);
    chk("y_row0", g0_r0, 32'hC0000001);
    chk("y_col0", g0_k0, 32'hD0000001);
    tick();
    tick();
    chk("y_b2row1", g0_r1, 32'hC0000004);
    chk("y_b2col1", g0_k1, 32'hD0000004);
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("to_ov0", 32'(g0_ov), 32'd0);
    end
    tick();
    chk("to_ov", 32'(g0_ov), 32'd1);
    chk("to_err", 32'(g0_err), 32'd1);
    chk("to_c", g0_c00 | g0_c01 | g0_c10 | g0_c11, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("to_rel_rdy", 32'(g0_rdy), 32'd1);
    chk("to_err_held", 32'(g0_err), 32'd1);

    // G=4 spacing, spurious done, capture and back-pressure
    set_ops(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h3F800000, 32'h0, 32'h0, 32'h3F800000);
    set_res('0, '0, '0, '0);
    iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    chk("g4b0_ld", 32'(g4_ld), 32'd1);
    chk("g4b0_row0", g4_r0, 32'h3F800000);
    for (int g = 0; g < 4; g++) begin
      arr_done = (g == 1);
      tick();
      chk("g4gap_ld", 32'(g4_ld), 32'd0);
      chk("g4gap_data", g4_r0 | g4_r1 | g4_k0 | g4_k1, 32'd0);
      chk("g4gap_ov", 32'(g4_ov), 32'd0);
    end
    arr_done = 1'b0;
    tick();
    chk("g4b1_ld", 32'(g4_ld), 32'd1);
    chk("g4b1_row1", g4_r1, 32'h40400000);
    chk("g4b1_row0", g4_r0, 32'h40000000);
    arr_done = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      arr_done = 1'b0;
      chk("g4gap2_ld", 32'(g4_ld), 32'd0);
      chk("g4gap2_ov", 32'(g4_ov), 32'd0);
    end
    tick();
    chk("g4b2_ld", 32'(g4_ld), 32'd1);
    chk("g4b2_col1", g4_k1, 32'h3F800000);
    tick();
    chk("g4w_ld", 32'(g4_ld), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("g4w_ov0", 32'(g4_ov), 32'd0);
    end
    set_res(32'h40E00000, 32'h41200000, 32'h41700000, 32'h41B00000);
    arr_done = 1'b1;
    tick();
    arr_done = 1'b0;
    set_res('0, '0, '0, '0);
    chk("cap_ov", 32'(g4_ov), 32'd1);
    chk("cap_err", 32'(g4_err), 32'd0);
    chk("cap_c00", g4_c00, 32'h40E00000);
    chk("cap_c01", g4_c01, 32'h41200000);
    chk("cap_c10", g4_c10, 32'h41700000);
    chk("cap_c11", g4_c11, 32'h41B00000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_ov", 32'(g4_ov), 32'd1);
      chk("hold_c01", g4_c01, 32'h41200000);
      chk("hold_rdy", 32'(g4_rdy), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("g4rel_ov", 32'(g4_ov), 32'd0);
    chk("g4rel_rdy", 32'(g4_rdy), 32'd1);
    chk("g4rel_busy", 32'(g4_busy), 32'd0);
    chk("g4rel_c11", g4_c11, 32'h41B00000);

    // reset during the gap after beat 1
    iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    for (int g = 0; g < 4; g++) tick();
    tick();
    chk("rr_b1_ld", 32'(g4_ld), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_ld", 32'(g4_ld), 32'd0);
    chk("rr_busy", 32'(g4_busy), 32'd0);
    chk("rr_rdy", 32'(g4_rdy), 32'd1);
    chk("rr_ov", 32'(g4_ov), 32'd0);
    chk("rr_data", g4_r0 | g4_r1 | g4_k0 | g4_k1, 32'd0);
    chk("rr_c", g4_c00 | g4_c01 | g4_c10 | g4_c11, 32'd0);
    set_ops(32'h3F000000, 32'h3E800000, 32'h3E000000, 32'h3D800000,
            32'h42000000, 32'h42100000, 32'h42200000, 32'h42300000);
    iv4 = 1'b1;
    tick();
    iv4 = 1'b0;
    chk("rn_ld", 32'(g4_ld), 32'd1);
    chk("rn_row0", g4_r0, 32'h3F000000);
    chk("rn_row1", g4_r1, 32'h0);
    chk("rn_col0", g4_k0, 32'h42000000);
    for (int g = 0; g < 5; g++) tick();
    chk("rn_b1_ld", 32'(g4_ld), 32'd1);
    chk("rn_b1_row1", g4_r1, 32'h3E000000);
    chk("rn_b1_col0", g4_k0, 32'h42200000);
    chk("rn_b1_col1", g4_k1, 32'h42100000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
